// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder buffer / retire slice.
package rob_retire_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = 4;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_DATA_W = 32;
  localparam int OP_W       = 7;

  localparam logic [OP_W-1:0] OP_SW = 7'b0100011;
  localparam logic [OP_W-1:0] OP_LW = 7'b0000011;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_PREG_W-1:0] pd;
    logic [ROB_PREG_W-1:0] old_pd;
    logic [OP_W-1:0]       op;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [ROB_PREG_W-1:0] pd;
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_PREG_W-1:0] free;
  } rob_row;

  // Stores retire without touching the architectural register file.
  function automatic logic writes_reg(input logic [OP_W-1:0] op);
    return op != OP_SW;
  endfunction

endpackage

// File: rtl/rob_retire_fwd_reg.sv
// Registered completion-forwarding path for one functional unit.
module rob_fwd_reg #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [PREG_W-1:0] result_dest,
  input  logic [DATA_W-1:0] result,
  output logic              f_flag,
  output logic [PREG_W-1:0] dest_r,
  output logic [DATA_W-1:0] f_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_flag <= 1'b0;
      dest_r <= '0;
      f_data <= '0;
    end else begin
      f_flag <= result_valid;
      dest_r <= result_dest;
      f_data <= result;
    end
  end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: pairwise allocation, three completion ports with forwarding,
// and in-order retirement of up to two entries per cycle.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int IDX_W  = ROB_IDX_W,
  parameter int PREG_W = ROB_PREG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] rob_p_1,
  input  logic [PREG_W-1:0] rob_p_2,
  input  logic [6:0]        rob_op_1,
  input  logic [6:0]        rob_op_2,
  input  logic [PREG_W-1:0] o_rob_p_1,
  input  logic [PREG_W-1:0] o_rob_p_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  rob_idx_1,
  output logic [IDX_W-1:0]  rob_idx_2,
  input  logic              result_valid_1,
  input  logic [IDX_W-1:0]  result_ROB_1,
  input  logic [PREG_W-1:0] result_dest_1,
  input  logic [DATA_W-1:0] result_1,
  input  logic              result_valid_2,
  input  logic [IDX_W-1:0]  result_ROB_2,
  input  logic [PREG_W-1:0] result_dest_2,
  input  logic [DATA_W-1:0] result_2,
  input  logic              result_valid_3,
  input  logic [IDX_W-1:0]  result_ROB_3,
  input  logic [PREG_W-1:0] result_dest_3,
  input  logic [DATA_W-1:0] result_3,
  output logic              f_flag_1,
  output logic [PREG_W-1:0] dest_r_1,
  output logic [DATA_W-1:0] f_data_1,
  output logic              f_flag_2,
  output logic [PREG_W-1:0] dest_r_2,
  output logic [DATA_W-1:0] f_data_2,
  output logic              f_flag_3,
  output logic [PREG_W-1:0] dest_r_3,
  output logic [DATA_W-1:0] f_data_3,
  output logic              ret_valid_1,
  output logic              ret_valid_2,
  output logic              ret_wen_1,
  output logic              ret_wen_2,
  output logic [PREG_W-1:0] ret_pd_1,
  output logic [PREG_W-1:0] ret_pd_2,
  output logic [DATA_W-1:0] ret_data_1,
  output logic [DATA_W-1:0] ret_data_2,
  output logic [PREG_W-1:0] ret_free_1,
  output logic [PREG_W-1:0] ret_free_2,
  output logic              cpl_err,
  output logic [IDX_W:0]    count
);

  rob_entry         ent   [DEPTH];
  rob_entry         ent_n [DEPTH];
  logic [IDX_W-1:0] head, tail, head_p1, tail_p1;
  logic [IDX_W:0]   cnt, cnt_n, nret;
  logic             alloc_fire, r1, r2, err, dup;
  logic [2:0]       rv, hit;
  logic [IDX_W-1:0] ridx [3];
  logic [DATA_W-1:0] rdat [3];
  rob_row           row1_n, row2_n, row1, row2;

  assign head_p1     = head + IDX_W'(1);
  assign tail_p1     = tail + IDX_W'(1);
  assign rob_idx_1   = tail;
  assign rob_idx_2   = tail_p1;
  assign count       = cnt;
  assign alloc_ready = cnt <= (IDX_W+1)'(DEPTH-2);
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign rv      = {result_valid_3, result_valid_2, result_valid_1};
  assign ridx[0] = result_ROB_1;
  assign ridx[1] = result_ROB_2;
  assign ridx[2] = result_ROB_3;
  assign rdat[0] = result_1;
  assign rdat[1] = result_2;
  assign rdat[2] = result_3;

  // A port loses to any lower-numbered port aiming at the same index.
  always_comb begin
    hit = '0;
    err = 1'b0;
    dup = 1'b0;
    for (int unsigned p = 0; p < 3; p++) begin
      if (rv[p]) begin
        dup = 1'b0;
        for (int unsigned q = 0; q < p; q++)
          if (rv[q] && ridx[q] == ridx[p]) dup = 1'b1;
        if (dup || !ent[ridx[p]].valid || ent[ridx[p]].done) err = 1'b1;
        else hit[p] = 1'b1;
      end
    end
  end

  assign r1   = ent[head].valid && ent[head].done;
  assign r2   = r1 && ent[head_p1].valid && ent[head_p1].done;
  assign nret = (IDX_W+1)'(r1) + (IDX_W+1)'(r2);
  assign cnt_n = cnt + (alloc_fire ? (IDX_W+1)'(2) : '0) - nret;

  always_comb begin
    row1_n = '0;
    row2_n = '0;
    if (r1) begin
      row1_n.valid = 1'b1;
      row1_n.wen   = writes_reg(ent[head].op);
      row1_n.pd    = ent[head].pd;
      row1_n.data  = ent[head].data;
      row1_n.free  = ent[head].old_pd;
    end
    if (r2) begin
      row2_n.valid = 1'b1;
      row2_n.wen   = writes_reg(ent[head_p1].op);
      row2_n.pd    = ent[head_p1].pd;
      row2_n.data  = ent[head_p1].data;
      row2_n.free  = ent[head_p1].old_pd;
    end
  end

  // Retire, allocation and completion never touch the same entry in one cycle,
  // so their updates can be layered in any order.
  always_comb begin
    ent_n = ent;
    if (r1) ent_n[head].valid = 1'b0;
    if (r2) ent_n[head_p1].valid = 1'b0;
    if (alloc_fire) begin
      ent_n[tail]    = '{valid: 1'b1, done: 1'b0, pd: rob_p_1, old_pd: o_rob_p_1,
                         op: rob_op_1, data: '0};
      ent_n[tail_p1] = '{valid: 1'b1, done: 1'b0, pd: rob_p_2, old_pd: o_rob_p_2,
                         op: rob_op_2, data: '0};
    end
    for (int unsigned p = 0; p < 3; p++) begin
      if (hit[p]) begin
        ent_n[ridx[p]].done = 1'b1;
        ent_n[ridx[p]].data = rdat[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      cpl_err <= 1'b0;
      row1    <= '0;
      row2    <= '0;
    end else begin
      ent     <= ent_n;
      head    <= head + nret[IDX_W-1:0];
      tail    <= alloc_fire ? tail + IDX_W'(2) : tail;
      cnt     <= cnt_n;
      cpl_err <= cpl_err | err;
      row1    <= row1_n;
      row2    <= row2_n;
    end
  end

  assign ret_valid_1 = row1.valid;
  assign ret_wen_1   = row1.wen;
  assign ret_pd_1    = row1.pd;
  assign ret_data_1  = row1.data;
  assign ret_free_1  = row1.free;
  assign ret_valid_2 = row2.valid;
  assign ret_wen_2   = row2.wen;
  assign ret_pd_2    = row2.pd;
  assign ret_data_2  = row2.data;
  assign ret_free_2  = row2.free;

  rob_fwd_reg #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_fwd_1 (
    .clk(clk), .rst(rst), .result_valid(result_valid_1), .result_dest(result_dest_1),
    .result(result_1), .f_flag(f_flag_1), .dest_r(dest_r_1), .f_data(f_data_1));
  rob_fwd_reg #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_fwd_2 (
    .clk(clk), .rst(rst), .result_valid(result_valid_2), .result_dest(result_dest_2),
    .result(result_2), .f_flag(f_flag_2), .dest_r(dest_r_2), .f_data(f_data_2));
  rob_fwd_reg #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_fwd_3 (
    .clk(clk), .rst(rst), .result_valid(result_valid_3), .result_dest(result_dest_3),
    .result(result_3), .f_flag(f_flag_3), .dest_r(dest_r_3), .f_data(f_data_3));

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with a program-order retire scoreboard.
module tb_rob_retire;
  import rob_retire_pkg::*;

  localparam int DEPTH = 16, IDX_W = 4, PREG_W = 6, DATA_W = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic              clk, rst, alloc_valid, alloc_ready;
  logic [PREG_W-1:0] rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2;
  logic [6:0]        rob_op_1, rob_op_2;
  logic [IDX_W-1:0]  rob_idx_1, rob_idx_2;
  logic              result_valid_1, result_valid_2, result_valid_3;
  logic [IDX_W-1:0]  result_ROB_1, result_ROB_2, result_ROB_3;
  logic [PREG_W-1:0] result_dest_1, result_dest_2, result_dest_3;
  logic [DATA_W-1:0] result_1, result_2, result_3;
  logic              f_flag_1, f_flag_2, f_flag_3;
  logic [PREG_W-1:0] dest_r_1, dest_r_2, dest_r_3;
  logic [DATA_W-1:0] f_data_1, f_data_2, f_data_3;
  logic              ret_valid_1, ret_valid_2, ret_wen_1, ret_wen_2;
  logic [PREG_W-1:0] ret_pd_1, ret_pd_2, ret_free_1, ret_free_2;
  logic [DATA_W-1:0] ret_data_1, ret_data_2;
  logic              cpl_err;
  logic [IDX_W:0]    count;

  rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid),
    .rob_p_1(rob_p_1), .rob_p_2(rob_p_2), .rob_op_1(rob_op_1), .rob_op_2(rob_op_2),
    .o_rob_p_1(o_rob_p_1), .o_rob_p_2(o_rob_p_2), .alloc_ready(alloc_ready),
    .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
    .result_valid_1(result_valid_1), .result_ROB_1(result_ROB_1),
    .result_dest_1(result_dest_1), .result_1(result_1),
    .result_valid_2(result_valid_2), .result_ROB_2(result_ROB_2),
    .result_dest_2(result_dest_2), .result_2(result_2),
    .result_valid_3(result_valid_3), .result_ROB_3(result_ROB_3),
    .result_dest_3(result_dest_3), .result_3(result_3),
    .f_flag_1(f_flag_1), .dest_r_1(dest_r_1), .f_data_1(f_data_1),
    .f_flag_2(f_flag_2), .dest_r_2(dest_r_2), .f_data_2(f_data_2),
    .f_flag_3(f_flag_3), .dest_r_3(dest_r_3), .f_data_3(f_data_3),
    .ret_valid_1(ret_valid_1), .ret_valid_2(ret_valid_2),
    .ret_wen_1(ret_wen_1), .ret_wen_2(ret_wen_2),
    .ret_pd_1(ret_pd_1), .ret_pd_2(ret_pd_2),
    .ret_data_1(ret_data_1), .ret_data_2(ret_data_2),
    .ret_free_1(ret_free_1), .ret_free_2(ret_free_2),
    .cpl_err(cpl_err), .count(count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model of ROB contents, indexed by entry.
  bit                m_valid [DEPTH];
  bit                m_done  [DEPTH];
  logic [PREG_W-1:0] m_pd    [DEPTH];
  logic [PREG_W-1:0] m_old   [DEPTH];
  logic [6:0]        m_op    [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];
  int                m_count, m_tail, last_nret;
  bit                m_err;
  int                exp_q[$];

  bit                cv   [3];
  int                cidx [3];
  logic [PREG_W-1:0] cdst [3];
  logic [DATA_W-1:0] cdat [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_done[i] = 0;
    end
    m_count = 0; m_tail = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; rob_p_1 = '0; rob_p_2 = '0; rob_op_1 = '0; rob_op_2 = '0;
    o_rob_p_1 = '0; o_rob_p_2 = '0;
    result_valid_1 = 0; result_ROB_1 = '0; result_dest_1 = '0; result_1 = '0;
    result_valid_2 = 0; result_ROB_2 = '0; result_dest_2 = '0; result_2 = '0;
    result_valid_3 = 0; result_ROB_3 = '0; result_dest_3 = '0; result_3 = '0;
    for (int p = 0; p < 3; p++) begin
      cv[p] = 0; cidx[p] = 0; cdst[p] = '0; cdat[p] = '0;
    end
  endtask

  task automatic do_alloc(input int pd1, input int pd2, input logic [6:0] op1,
                          input logic [6:0] op2, input int old1, input int old2);
    chk("alloc_ready", alloc_ready, m_count <= DEPTH - 2);
    chk("rob_idx_1", rob_idx_1, m_tail);
    chk("rob_idx_2", rob_idx_2, (m_tail + 1) % DEPTH);
    alloc_valid = 1;
    rob_p_1 = PREG_W'(pd1); rob_p_2 = PREG_W'(pd2);
    rob_op_1 = op1; rob_op_2 = op2;
    o_rob_p_1 = PREG_W'(old1); o_rob_p_2 = PREG_W'(old2);
    if (m_count <= DEPTH - 2) begin
      for (int s = 0; s < 2; s++) begin
        int e;
        e = (m_tail + s) % DEPTH;
        m_valid[e] = 1; m_done[e] = 0;
        m_pd[e]  = PREG_W'(s == 0 ? pd1 : pd2);
        m_old[e] = PREG_W'(s == 0 ? old1 : old2);
        m_op[e]  = (s == 0) ? op1 : op2;
        exp_q.push_back(e);
      end
      m_tail  = (m_tail + 2) % DEPTH;
      m_count = m_count + 2;
    end
  endtask

  task automatic drv_cpl(input int p, input int idx, input int dest, input logic [DATA_W-1:0] d);
    cv[p-1] = 1; cidx[p-1] = idx; cdst[p-1] = PREG_W'(dest); cdat[p-1] = d;
    case (p)
      1: begin result_valid_1 = 1; result_ROB_1 = IDX_W'(idx); result_dest_1 = PREG_W'(dest); result_1 = d; end
      2: begin result_valid_2 = 1; result_ROB_2 = IDX_W'(idx); result_dest_2 = PREG_W'(dest); result_2 = d; end
      default: begin result_valid_3 = 1; result_ROB_3 = IDX_W'(idx); result_dest_3 = PREG_W'(dest); result_3 = d; end
    endcase
  endtask

  task automatic retire_check(input string s, input logic [PREG_W-1:0] pd,
                              input logic [DATA_W-1:0] data, input logic [PREG_W-1:0] fr,
                              input logic wen);
    int e;
    chk({s, "_expected"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({s, "_done_in_model"}, m_done[e], 1);
      chk({s, "_pd"}, pd, m_pd[e]);
      chk({s, "_data"}, data, m_data[e]);
      chk({s, "_free"}, fr, m_old[e]);
      chk({s, "_wen"}, wen, m_op[e] != OP_SW);
      m_valid[e] = 0;
      m_count--;
      last_nret++;
    end
  endtask

  task automatic step();
    bit                ef [3];
    logic [PREG_W-1:0] ed [3];
    logic [DATA_W-1:0] ex [3];
    for (int p = 0; p < 3; p++) begin
      ef[p] = cv[p]; ed[p] = cdst[p]; ex[p] = cdat[p];
      if (cv[p]) begin
        bit dupl;
        dupl = 0;
        for (int q = 0; q < p; q++) if (cv[q] && cidx[q] == cidx[p]) dupl = 1;
        if (dupl || !m_valid[cidx[p]] || m_done[cidx[p]]) m_err = 1;
        else begin
          m_done[cidx[p]] = 1;
          m_data[cidx[p]] = cdat[p];
        end
      end
    end
    @(posedge clk);
    #1;
    last_nret = 0;
    if (ret_valid_1) retire_check("ret1", ret_pd_1, ret_data_1, ret_free_1, ret_wen_1);
    if (ret_valid_2) begin
      chk("ret2_needs_ret1", ret_valid_1, 1);
      retire_check("ret2", ret_pd_2, ret_data_2, ret_free_2, ret_wen_2);
    end
    chk("f_flag_1", f_flag_1, ef[0]); chk("dest_r_1", dest_r_1, ed[0]); chk("f_data_1", f_data_1, ex[0]);
    chk("f_flag_2", f_flag_2, ef[1]); chk("dest_r_2", dest_r_2, ed[1]); chk("f_data_2", f_data_2, ex[1]);
    chk("f_flag_3", f_flag_3, ef[2]); chk("dest_r_3", dest_r_3, ed[2]); chk("f_data_3", f_data_3, ex[2]);
    chk("cpl_err", cpl_err, m_err);
    chk("count", count, m_count);
    clear_inputs();
  endtask

  task automatic drain();
    for (int it = 0; it < 60 && exp_q.size() > 0; it++) begin
      int n;
      n = 0;
      foreach (exp_q[k]) begin
        if (n < 3 && m_valid[exp_q[k]] && !m_done[exp_q[k]]) begin
          drv_cpl(n + 1, exp_q[k], m_pd[exp_q[k]], $urandom);
          n++;
        end
      end
      step();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int a;
    clear_inputs();
    model_clear();
    rst = 1;
    result_valid_1 = 1; result_dest_1 = 6'd7; result_1 = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_rob_idx_1", rob_idx_1, 0);
    chk("rst_ret_valid_1", ret_valid_1, 0);
    chk("rst_ret_valid_2", ret_valid_2, 0);
    chk("rst_f_flag_1", f_flag_1, 0);
    chk("rst_f_data_1", f_data_1, 0);
    chk("rst_cpl_err", cpl_err, 0);
    clear_inputs();
    rst = 0;

    // Pair allocation, out-of-order completion, joint retirement.
    do_alloc(33, 34, OP_ADD, OP_ADD, 1, 2);
    step();
    drv_cpl(1, 1, 34, 32'hB1);
    step();
    chk("no_retire_before_head", ret_valid_1, 0);
    drv_cpl(1, 0, 33, 32'hA0);
    step();
    chk("no_retire_same_edge", ret_valid_1, 0);
    step();
    chk("pair_retired", last_nret, 2);
    chk("pair_free_1", ret_free_1, 1);
    chk("pair_free_2", ret_free_2, 2);
    chk("pair_count", count, 0);

    // Fill to capacity; a further request must be ignored.
    for (int i = 0; i < 8; i++) begin
      do_alloc(10 + 2 * i, 11 + 2 * i, OP_LW, OP_ADD, 40 + i, 50 + i);
      step();
    end
    chk("full_count", count, 16);
    chk("full_not_ready", alloc_ready, 0);
    do_alloc(60, 61, OP_ADD, OP_ADD, 62, 63);
    step();
    chk("full_ignored_count", count, 16);
    chk("full_ignored_tail", rob_idx_1, 2);
    drv_cpl(1, 2, 10, 32'h22);
    drv_cpl(2, 3, 11, 32'h33);
    step();
    chk("full_still_not_ready", alloc_ready, 0);
    step();
    chk("full_retire_two", last_nret, 2);
    chk("ready_after_retire", alloc_ready, 1);
    drain();

    // Three simultaneous completions and their forwarded copies.
    do_alloc(20, 21, OP_ADD, OP_ADD, 3, 4);
    step();
    do_alloc(22, 23, OP_ADD, OP_ADD, 5, 6);
    step();
    drv_cpl(1, 2, 40, 32'd5);
    drv_cpl(2, 3, 41, 32'd7);
    drv_cpl(3, 4, 42, 32'd9);
    step();
    chk("fwd3_flags", {f_flag_1, f_flag_2, f_flag_3}, 3'b111);
    chk("fwd3_dest", {dest_r_1, dest_r_2, dest_r_3}, {6'd40, 6'd41, 6'd42});
    chk("fwd3_data", {f_data_1, f_data_2}, {32'd5, 32'd7});
    chk("fwd3_data_3", f_data_3, 32'd9);
    drain();

    // Store at the head retires without a register write.
    a = m_tail;
    do_alloc(50, 51, OP_SW, OP_ADD, 7, 8);
    step();
    drv_cpl(1, a, 50, 32'h5);
    drv_cpl(2, (a + 1) % DEPTH, 51, 32'h6);
    step();
    step();
    chk("sw_ret_valid_1", ret_valid_1, 1);
    chk("sw_ret_wen_1", ret_wen_1, 0);
    chk("sw_ret_wen_2", ret_wen_2, 1);

    // Completion errors: unallocated index, then a same-index collision.
    drv_cpl(1, 9, 12, 32'h99);
    step();
    chk("err_unalloc", cpl_err, 1);
    a = m_tail;
    do_alloc(30, 31, OP_ADD, OP_ADD, 9, 10);
    step();
    drv_cpl(1, a, 30, 32'h111);
    drv_cpl(2, a, 30, 32'h222);
    step();
    drv_cpl(1, (a + 1) % DEPTH, 31, 32'h333);
    step();
    chk("collide_port1_wins", ret_data_1, 32'h111);
    chk("err_sticky", cpl_err, 1);
    drain();

    // Twenty pairs spanning several index wrap-arounds.
    for (int i = 0; i < 20; i++) begin
      a = m_tail;
      do_alloc(i % 32, 32 + i % 32, (i % 3 == 0) ? OP_SW : OP_ADD, OP_LW, i, 63 - i);
      step();
      drv_cpl(1, a, i % 32, 32'h1000 + i);
      drv_cpl(2, (a + 1) % DEPTH, 32 + i % 32, 32'h2000 + i);
      step();
    end

    // Asynchronous reset mid-stream with retirements in flight.
    a = m_tail;
    do_alloc(1, 2, OP_ADD, OP_ADD, 3, 4);
    step();
    drv_cpl(1, a, 1, 32'h77);
    drv_cpl(2, (a + 1) % DEPTH, 2, 32'h78);
    step();
    do_alloc(5, 6, OP_ADD, OP_ADD, 7, 8);
    result_valid_3 = 1; result_dest_3 = 6'd9; result_3 = 32'h5A;
    #3;
    rst = 1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_ret_valid_1", ret_valid_1, 0);
    chk("async_rst_ret_valid_2", ret_valid_2, 0);
    chk("async_rst_alloc_ready", alloc_ready, 1);
    chk("async_rst_cpl_err", cpl_err, 0);
    chk("async_rst_idx", rob_idx_1, 0);
    @(posedge clk);
    #1;
    chk("rst_discards_fwd", f_flag_3, 0);
    chk("rst_discards_alloc", count, 0);
    clear_inputs();
    model_clear();
    rst = 0;

    do_alloc(11, 12, OP_ADD, OP_ADD, 13, 14);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
